aes_byte_bridge: RTL
====================

# aes_byte_bridge

Host-side driver and collector for the 8-bit byte-serial AES core `aes_8_bit`. It takes a 128-bit key and a 128-bit plaintext from a host in one request, then pulses the core reset. It streams both operands into the core one byte per cycle, MSB byte first, and reassembles the core's 16 output bytes into a 128-bit ciphertext. It sits between a register or bus front-end and the core, and replaces hand-sequenced byte feeding.

## Interface
Parameters:
- RST_CYCLES, 1, number of cycles core_rst is held high before loading (≥1)
- TIMEOUT, 1024, maximum idle cycles allowed while waiting for any d_vld byte (≥16)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request pulse; accepted only when busy=0
- key  in  128  cipher key, sampled on accepted start
- pt  in  128  plaintext, sampled on accepted start
- busy  out  1  high from the cycle after an accepted start until return to IDLE
- ct  out  128  assembled ciphertext, held until the next accepted start
- ct_vld  out  1  one-cycle pulse when ct is complete
- err  out  1  one-cycle pulse on timeout
- core_rst  out  1  reset to the core
- key_in  out  8  key byte to the core
- d_in  out  8  data byte to the core
- d_out  in  8  ciphertext byte from the core
- d_vld  in  1  d_out valid qualifier

## Operation
- Reset values: busy=0, ct=0, ct_vld=0, err=0, core_rst=1, key_in=0, d_in=0, state=IDLE, all counters 0.
- **IDLE**: core_rst=0. On start=1, latch key and pt into shift registers and go to RST.
- **RST**: core_rst=1 for RST_CYCLES cycles, then go to LOAD.
- **LOAD**: runs 16 cycles. In LOAD cycle i (0..15), key_in=key[127-8i -: 8] and d_in=pt[127-8i -: 8]. Implementation shifts both registers left by 8 each cycle. After cycle 15 go to WAIT. key_in and d_in are 0 in every state other than LOAD.
- **WAIT**: on d_vld=1, capture the byte and go to COLLECT.
- **COLLECT**: on each cycle with d_vld=1, ct_shift <= {ct_shift[119:0], d_out} and increment the byte count. Gaps in d_vld are tolerated. When the 16th byte is captured, go to DONE.
- **DONE**: ct <= ct_shift, ct_vld=1 for this cycle only, then go to IDLE.
- Timeout: a counter resets on entry to WAIT and on each captured byte, and increments otherwise. When it reaches TIMEOUT in WAIT or COLLECT: err=1 for one cycle, go to IDLE, ct unchanged, no ct_vld.
- d_vld is ignored in IDLE, RST and LOAD.
- start while busy=1 is ignored; no queueing.
- The byte counter is 4-bit. It wraps 15→0 only on the DONE transition and never overflows into a 17th capture.
- rst asserted in any state immediately forces all reset values, including core_rst=1. The in-flight operation is discarded.

## Timing
- Accepted start at edge E0 → busy=1 and core_rst=1 from E0.
- core_rst falls at E0+RST_CYCLES.
- The first key/data byte is present during cycle E0+RST_CYCLES. The last byte is present during cycle E0+RST_CYCLES+15.
- The byte arriving with the 16th d_vld is captured at edge Ek.
- ct is updated and ct_vld is high during the cycle after Ek. busy falls one cycle later.
- A new start is accepted on the same edge that busy is first observed 0.
- All outputs are registered; there are no combinational paths from host inputs or core inputs to outputs.

## Structure
- Package aes_bridge_pkg holds:
  - state enum {IDLE, RST, LOAD, WAIT, COLLECT, DONE}
  - AES_BYTES=16
  - BLOCK_W=128
- The design is a single flat module; no sub-module is warranted.
- Timeout counter width is $clog2(TIMEOUT+1).

## Test plan
- **FIPS-197 Appendix C.1**: key=000102030405060708090a0b0c0d0e0f, pt=00112233445566778899aabbccddeeff, with the real core → ct=69c4e0d86a7b0430d8cdb78070b4c55a, one ct_vld pulse, err=0.
- **FIPS-197 Appendix B**: key=2b7e151628aed2a6abf7158809cf4f3c, pt=3243f6a8885a308d313198a2e0370734, issued back-to-back after the first vector → ct=3925841d02dc09fbdc118597196a0b32.
- **Core stub emitting bytes 0x00..0x0F with random one-to-three-cycle d_vld gaps** → ct=000102030405060708090a0b0c0d0e0f. Check key_in/d_in byte order against pt in LOAD.
- **Stub never asserts d_vld, TIMEOUT=32** → err pulses exactly 32 cycles after entering WAIT, busy drops, ct_vld stays 0, ct holds its previous value.
- **start pulsed during LOAD** → ignored. Exactly 16 load cycles occur and the ciphertext is unchanged.
- **rst asserted mid-COLLECT** → all outputs at reset values on the same cycle. A fresh start afterwards completes correctly.

Source files
------------

// File: rtl/aes_bridge_pkg.sv
// Shared types and sizes for the AES byte-serial bridge.
package aes_bridge_pkg;

    localparam int AES_BYTES = 16;
    localparam int BLOCK_W   = 128;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        LOAD,
        WAIT,
        COLLECT,
        DONE
    } state_t;

endpackage

// File: rtl/aes_byte_bridge.sv
// Host-side driver for the byte-serial AES core: resets the core, streams key and
// plaintext MSB byte first, then reassembles the 16 returned bytes into ct.
module aes_byte_bridge
    import aes_bridge_pkg::*;
#(
    parameter int RST_CYCLES = 1,
    parameter int TIMEOUT    = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BLOCK_W-1:0] key,
    input  logic [BLOCK_W-1:0] pt,
    output logic               busy,
    output logic [BLOCK_W-1:0] ct,
    output logic               ct_vld,
    output logic               err,
    output logic               core_rst,
    output logic [7:0]         key_in,
    output logic [7:0]         d_in,
    input  logic [7:0]         d_out,
    input  logic               d_vld
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [3:0]    LAST_BYTE = 4'(AES_BYTES - 1);

    state_t             state;
    state_t             state_nxt;
    logic [BLOCK_W-1:0] key_sr;
    logic [BLOCK_W-1:0] pt_sr;
    logic [BLOCK_W-1:0] ct_shift;
    logic [3:0]         load_cnt;
    logic [3:0]         byte_cnt;
    logic [RW-1:0]      rst_cnt;
    logic [TW-1:0]      tcnt;
    logic               collecting;
    logic               capture;
    logic               timeout_hit;
    logic               busy_nxt;
    logic               core_rst_nxt;
    logic               ct_vld_nxt;
    logic               err_nxt;
    logic [7:0]         key_in_nxt;
    logic [7:0]         d_in_nxt;

    // The timeout fires on the edge where the idle count would reach TIMEOUT.
    assign collecting  = (state == WAIT) || (state == COLLECT);
    assign capture     = collecting && d_vld;
    assign timeout_hit = collecting && !d_vld && (tcnt == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RST;
            RST:     if (rst_cnt == RST_LAST) state_nxt = LOAD;
            LOAD:    if (load_cnt == LAST_BYTE) state_nxt = WAIT;
            WAIT: begin
                if (d_vld) begin
                    state_nxt = COLLECT;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            COLLECT: begin
                if (d_vld && (byte_cnt == LAST_BYTE)) begin
                    state_nxt = DONE;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with it once registered.
    always_comb begin
        busy_nxt     = (state_nxt != IDLE);
        core_rst_nxt = (state_nxt == RST);
        ct_vld_nxt   = (state_nxt == DONE);
        err_nxt      = timeout_hit;
        key_in_nxt   = '0;
        d_in_nxt     = '0;
        if (state_nxt == LOAD) begin
            key_in_nxt = key_sr[BLOCK_W-1 -: 8];
            d_in_nxt   = pt_sr[BLOCK_W-1 -: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            core_rst <= 1'b1;
            ct_vld   <= 1'b0;
            err      <= 1'b0;
            key_in   <= '0;
            d_in     <= '0;
        end else begin
            busy     <= busy_nxt;
            core_rst <= core_rst_nxt;
            ct_vld   <= ct_vld_nxt;
            err      <= err_nxt;
            key_in   <= key_in_nxt;
            d_in     <= d_in_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_sr   <= '0;
            pt_sr    <= '0;
            ct_shift <= '0;
            ct       <= '0;
            load_cnt <= '0;
            byte_cnt <= '0;
            rst_cnt  <= '0;
            tcnt     <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                key_sr   <= key;
                pt_sr    <= pt;
                rst_cnt  <= '0;
                byte_cnt <= '0;
            end
            if (state == RST) begin
                rst_cnt <= rst_cnt + 1'b1;
            end
            if (state_nxt == LOAD) begin
                key_sr <= key_sr << 8;
                pt_sr  <= pt_sr << 8;
            end
            if (state == LOAD) begin
                load_cnt <= load_cnt + 1'b1;
                tcnt     <= '0;
            end
            // byte_cnt wraps 15->0 exactly on the capture that moves to DONE.
            if (capture) begin
                ct_shift <= {ct_shift[BLOCK_W-9:0], d_out};
                byte_cnt <= byte_cnt + 1'b1;
                tcnt     <= '0;
            end else if (collecting) begin
                tcnt <= tcnt + 1'b1;
            end
            if (state_nxt == DONE) begin
                ct <= {ct_shift[BLOCK_W-9:0], d_out};
            end
        end
    end

endmodule
